bram_read_checker: RTL
======================

BRAM_READ_CHECKER -- requirements
Module: bram_read_checker

Interface
REQ-001 Parameter EXP_MODE, default 0, selects the expected-word rule: 0 = constant EXP_CONST, 1 = {addr, ~addr}.
REQ-002 Parameter EXP_CONST, default 16'hFFFF, is the expected word when EXP_MODE = 0.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1, sole clock; every register updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, requests one full scan; sampled only in IDLE.
REQ-007 Port raddr, output, 8, read address to the 256x16 RAM read port.
REQ-008 Port re, output, 1, read enable to the RAM.
REQ-009 Port rclke, output, 1, read clock enable to the RAM; equals re.
REQ-010 Port rdata, input, 16, RAM read data, valid the cycle after re/raddr are presented.
REQ-011 Port busy, output, 1, high in READ and DRAIN.
REQ-012 Port done, output, 1, single-cycle pulse when a scan completes.
REQ-013 Port pass, output, 1, result of the last completed scan; held until the next start.
REQ-014 Port err_count, output, 9, number of mismatching words in the current or last scan (0..256).
REQ-015 Port first_err_addr, output, 8, address of the first mismatch in the scan.
REQ-016 Port first_err_data, output, 16, rdata captured at the first mismatch.

Function
REQ-017 FSM states SHALL be IDLE, READ, DRAIN and DONE.
REQ-018 IDLE with start = 1 at an edge SHALL go to READ and, at that edge, set raddr = 0 and re = 1, clear err_count, first_err_addr and first_err_data, and clear pass.
REQ-019 In READ, raddr SHALL increment by 1 per cycle with re = 1, presenting addresses 0..255 on 256 consecutive cycles.
REQ-020 Leaving READ SHALL happen on the edge where raddr = 255; that edge goes to DRAIN with re = 0 and raddr held at 255; raddr SHALL never wrap to 0 within a scan.
REQ-021 Compare pipeline: a 1-cycle delayed copy of re and raddr (cmp_valid, cmp_addr) SHALL qualify rdata; when cmp_valid = 1, rdata is compared with the expected word for cmp_addr.
REQ-022 On a mismatch, err_count SHALL increment by 1; err_count maxes at exactly 256 and SHALL NOT overflow.
REQ-023 On the first mismatch of a scan (err_count = 0 before the increment), first_err_addr and first_err_data SHALL be captured; later mismatches SHALL NOT overwrite them.
REQ-024 DRAIN SHALL last exactly one cycle, during which the address-255 word is compared, then go to DONE.
REQ-025 DONE SHALL last one cycle with done = 1, pass = (err_count = 0), then return to IDLE.
REQ-026 Latency: start sampled at edge E0 -> done high during the cycle after edge E0+257; busy high from after E0 until edge E0+257.
REQ-027 start SHALL be ignored in READ, DRAIN and DONE; no restart or queuing.
REQ-028 start held high continuously SHALL begin a new scan on the first IDLE edge after DONE.
REQ-029 Expected word in mode 1 SHALL be {cmp_addr[7:0], ~cmp_addr[7:0]}.

Reset
REQ-030 rst SHALL force, immediately and regardless of clk: state IDLE, raddr = 0, re = 0, rclke = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_err_addr = 0, first_err_data = 0, cmp_valid = 0.
REQ-031 rst asserted mid-scan SHALL abort the scan with no done pulse; a following start SHALL run a complete fresh scan.

Verification
REQ-032 Memory model returns EXP_CONST (mode 0) at all 256 addresses; pulse start -> re high for 256 cycles, done pulse 258 cycles after start, pass = 1, err_count = 0.
REQ-033 Mode 1, memory = {a, ~a} except address 0x3A = 16'h1234 -> err_count = 1, first_err_addr = 8'h3A, first_err_data = 16'h1234, pass = 0.
REQ-034 Mode 0, memory all 16'h0000 -> err_count = 256, first_err_addr = 8'h00, first_err_data = 16'h0000, pass = 0.
REQ-035 Mismatch only at address 255 -> err_count = 1, first_err_addr = 8'hFF (exercises DRAIN compare).
REQ-036 Second start pulse 10 cycles into a scan -> ignored; exactly one done pulse, 258 cycles after the first start.
REQ-037 rst asserted at raddr = 100 -> all outputs reach reset values without a clock edge; no done pulse; next start gives a full 256-read scan.

Source files
------------

// File: rtl/bram_read_checker.sv
// bram_read_checker
// Scans a 256x16 synchronous-read RAM from address 0 to 255, compares each
// returned word with an expected pattern and reports the result.
//
// Parameters
//   EXP_MODE  : 0 = every word must equal EXP_CONST, 1 = word must be {addr, ~addr}
//   EXP_CONST : expected word used when EXP_MODE = 0
//
// Ports
//   clk            in   sole clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   request one full scan (sampled only while idle)
//   raddr          out  RAM read address
//   re             out  RAM read enable
//   rclke          out  RAM read clock enable (mirrors re)
//   rdata          in   RAM read data, valid one cycle after re/raddr
//   busy           out  high while reading and draining the compare pipeline
//   done           out  one-cycle pulse at the end of a scan
//   pass           out  result of the last completed scan
//   err_count      out  mismatch count of the current/last scan (0..256)
//   first_err_addr out  address of the first mismatch
//   first_err_data out  data read at the first mismatch
module bram_read_checker #(
  parameter int          EXP_MODE  = 0,
  parameter logic [15:0] EXP_CONST = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  raddr,
  output logic        re,
  output logic        rclke,
  input  logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_count,
  output logic [7:0]  first_err_addr,
  output logic [15:0] first_err_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_r;
  logic        cmp_valid_r;
  logic [7:0]  cmp_addr_r;
  logic        mism_s;
  logic [8:0]  err_next_s;

  // Expected RAM contents for a given address.
  function automatic logic [15:0] exp_word(input logic [7:0] addr);
    if (EXP_MODE == 1) begin
      return {addr, ~addr};
    end else begin
      return EXP_CONST;
    end
  endfunction

  // The enable is a registered output, so the clock enable can simply follow it.
  assign rclke = re;

  // Mismatch detection on the delayed address and the saturating next count.
  always_comb begin
    mism_s     = 1'b0;
    err_next_s = err_count;
    if (cmp_valid_r && (rdata != exp_word(cmp_addr_r))) begin
      mism_s = 1'b1;
    end else begin
      mism_s = 1'b0;
    end
    if (mism_s && (err_count != 9'd256)) begin
      err_next_s = err_count + 9'd1;
    end else begin
      err_next_s = err_count;
    end
  end

  // Scan FSM, compare pipeline and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      raddr          <= 8'd0;
      re             <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= 9'd0;
      first_err_addr <= 8'd0;
      first_err_data <= 16'd0;
      cmp_valid_r    <= 1'b0;
      cmp_addr_r     <= 8'd0;
    end else begin
      // rdata belongs to the address presented one cycle earlier.
      cmp_valid_r <= re;
      cmp_addr_r  <= raddr;
      done        <= 1'b0;

      if (mism_s) begin
        err_count <= err_next_s;
        // Only the first mismatch of a scan is recorded.
        if (err_count == 9'd0) begin
          first_err_addr <= cmp_addr_r;
          first_err_data <= rdata;
        end
      end

      case (state_r)
        IDLE: begin
          if (start) begin
            state_r        <= READ;
            raddr          <= 8'd0;
            re             <= 1'b1;
            busy           <= 1'b1;
            pass           <= 1'b0;
            err_count      <= 9'd0;
            first_err_addr <= 8'd0;
            first_err_data <= 16'd0;
          end
        end
        READ: begin
          // Stop at 255 instead of wrapping so the last address stays on the bus.
          if (raddr == 8'd255) begin
            state_r <= DRAIN;
            re      <= 1'b0;
          end else begin
            raddr <= raddr + 8'd1;
          end
        end
        DRAIN: begin
          // The address-255 word is compared on this same edge, so the verdict
          // uses the updated count.
          state_r <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (err_next_s == 9'd0);
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          re      <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
